tt_um_hoene_led_fader: RTL
==========================

Name: tt_um_hoene_led_fader

Overview:
Sits between tt_um_hoene_protocol_serial2parallel and tt_um_hoene_led_pwm. It latches new 10-bit RGB targets when a frame is stored. It then ramps each PWM duty value toward its target at a fixed step per prescaler tick, so colour changes are smooth instead of abrupt. With fading disabled it passes the targets through, one cycle after the load.

Parameters:
WIDTH, 10, bits per colour channel
PRESCALE_BITS, 8, one fade tick every 2^PRESCALE_BITS clk cycles
STEP, 1, magnitude added or subtracted per tick per channel (1 <= STEP < 2^WIDTH)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
target_red  input  WIDTH  new red duty (protocol_output_data[10:1])
target_green  input  WIDTH  new green duty (protocol_output_data[20:11])
target_blue  input  WIDTH  new blue duty (protocol_output_data[30:21])
load  input  1  one-cycle strobe; latch the three targets
fade_enable  input  1  1 = ramp toward targets, 0 = snap to targets
out_red  output  WIDTH  current red duty, to led_pwm data_red
out_green  output  WIDTH  current green duty, to led_pwm data_green
out_blue  output  WIDTH  current blue duty, to led_pwm data_blue
busy  output  1  1 while any out_* differs from its latched target

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset: out_* = 0, internal targets = 0, prescaler = 0, busy = 0, state = IDLE.
- Target latch: when load = 1, the internal target registers take target_* at that clk edge. Inputs are ignored at all other times.
- Prescaler:
  - PRESCALE_BITS-wide up-counter that wraps naturally.
  - A tick is the cycle in which prescaler = 2^PRESCALE_BITS-1.
  - A load cycle clears the prescaler to 0, so the first step happens exactly 2^PRESCALE_BITS cycles after the load edge.
- States:
  - IDLE: all out_* equal their targets.
  - FADING: at least one channel differs.
  - IDLE -> FADING: on the edge after a load whose latched targets differ from out_*, with fade_enable = 1.
  - FADING -> IDLE: on the tick where the last differing channel reaches its target.
- Per-channel step, on each tick in FADING:
  - if out < target: out <= (target - out <= STEP) ? target : out + STEP
  - if out > target: out <= (out - target <= STEP) ? target : out - STEP
  - Arithmetic uses WIDTH+1 bits internally. out_* never wraps and never overshoots.
- Channels step independently. A channel already at its target holds.
- fade_enable = 0:
  - out_* <= targets on every cycle. A load therefore shows on out_* after 1 cycle.
  - state goes to IDLE.
  - busy = 0 from the cycle after the snap.
- fade_enable falling during FADING: outputs snap to targets on the next edge.
- fade_enable rising while out_* equals targets: no change.
- Load and tick in the same cycle: load wins. No step that cycle, prescaler cleared.
- Load during FADING: new targets take effect immediately. Ramping continues from the current out_* toward the new targets, with no jump.
- busy is registered. It is 1 in every cycle where state = FADING and 0 in IDLE. It goes high one cycle after the load edge.
- Reset asserted mid-fade: everything returns to reset values on that edge. The in-progress fade is discarded.

Test Plan:
(Bench uses PRESCALE_BITS=2, STEP=1 unless noted.)
1. Reset and snap: release reset, fade_enable = 0, load pulse with R=0x3FF, G=0x155, B=0x000 -> out_* = 0 during reset; one cycle after load out = {0x3FF, 0x155, 0x000}; busy stays 0.
2. Ramp up: fade_enable = 1, from 0 load R=3, G=0, B=1 -> busy = 1; R steps 1, 2, 3 at 4, 8, 12 cycles after load; B reaches 1 at cycle 4; busy drops the cycle after R = 3.
3. Ramp down with clamp: STEP=4, out R=10, load R=0 -> R goes 6, 2, 0; never wraps to 0x3FE.
4. Retarget mid-fade: from R=0 ramping toward 8, at R=3 load R=1 -> R goes 2 then 1; prescaler restarts, so the next step is 4 cycles after the second load.
5. Load on tick: assert load in the tick cycle -> no step occurs; the next step comes 4 cycles later.
6. Disable and reset mid-fade: at R=5 toward 20, drop fade_enable -> R = 20 next cycle, busy = 0. Repeat the fade and assert rst_n = 0 mid-fade -> out_* = 0 and busy = 0 on the next edge.

Source files
------------

// File: rtl/tt_um_hoene_led_fader.sv
// RGB duty fader: latches 10-bit colour targets on load and ramps the PWM duty
// values toward them one STEP per prescaler tick, or snaps when fading is off.
module tt_um_hoene_led_fader #(
    parameter int WIDTH         = 10,
    parameter int PRESCALE_BITS = 8,
    parameter int STEP          = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] target_red,
    input  logic [WIDTH-1:0] target_green,
    input  logic [WIDTH-1:0] target_blue,
    input  logic             load,
    input  logic             fade_enable,
    output logic [WIDTH-1:0] out_red,
    output logic [WIDTH-1:0] out_green,
    output logic [WIDTH-1:0] out_blue,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        FADING
    } state_t;

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

    state_t                   r_state;
    logic                     r_busy;
    logic [PRESCALE_BITS-1:0] r_prescale;
    logic [WIDTH-1:0]         r_tgt_red, r_tgt_green, r_tgt_blue;
    logic [WIDTH-1:0]         r_out_red, r_out_green, r_out_blue;

    logic                     w_tick;
    logic                     w_step_en;
    logic                     w_differs;
    logic [WIDTH-1:0]         w_next_red, w_next_green, w_next_blue;

    // One clamped step toward the target; the extra bit keeps the compare wrap-free.
    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] tgt);
        logic [WIDTH:0] cur_ext;
        logic [WIDTH:0] tgt_ext;
        cur_ext = {1'b0, cur};
        tgt_ext = {1'b0, tgt};
        if (cur_ext < tgt_ext)
            f_step = (tgt_ext - cur_ext <= STEP_EXT) ? tgt : WIDTH'(cur_ext + STEP_EXT);
        else if (cur_ext > tgt_ext)
            f_step = (cur_ext - tgt_ext <= STEP_EXT) ? tgt : WIDTH'(cur_ext - STEP_EXT);
        else
            f_step = cur;
    endfunction

    // A load in the tick cycle suppresses the step and restarts the prescaler.
    assign w_tick    = &r_prescale;
    assign w_step_en = (r_state == FADING) && w_tick && !load;

    always_comb begin
        w_next_red   = r_out_red;
        w_next_green = r_out_green;
        w_next_blue  = r_out_blue;
        if (w_step_en) begin
            w_next_red   = f_step(r_out_red,   r_tgt_red);
            w_next_green = f_step(r_out_green, r_tgt_green);
            w_next_blue  = f_step(r_out_blue,  r_tgt_blue);
        end
    end

    // NOTE: state follows the post-step outputs so busy falls on the final step edge.
    assign w_differs = (w_next_red   != r_tgt_red)   ||
                       (w_next_green != r_tgt_green) ||
                       (w_next_blue  != r_tgt_blue);

    // NOTE: all state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_prescale  <= '0;
            r_tgt_red   <= '0;
            r_tgt_green <= '0;
            r_tgt_blue  <= '0;
            r_out_red   <= '0;
            r_out_green <= '0;
            r_out_blue  <= '0;
        end else begin
            if (load) begin
                r_tgt_red   <= target_red;
                r_tgt_green <= target_green;
                r_tgt_blue  <= target_blue;
            end
            r_prescale <= load ? '0 : r_prescale + 1'b1;

            if (!fade_enable) begin
                r_out_red   <= r_tgt_red;
                r_out_green <= r_tgt_green;
                r_out_blue  <= r_tgt_blue;
                r_state     <= IDLE;
                r_busy      <= 1'b0;
            end else begin
                r_out_red   <= w_next_red;
                r_out_green <= w_next_green;
                r_out_blue  <= w_next_blue;
                r_state     <= w_differs ? FADING : IDLE;
                r_busy      <= w_differs;
            end
        end
    end

    assign out_red   = r_out_red;
    assign out_green = r_out_green;
    assign out_blue  = r_out_blue;
    assign busy      = r_busy;

endmodule
